// File: rtl/sme_param.sv
// Parametrised string-matching engine: byte-serial string/pattern load, then a
// one-character-per-cycle search with '^'/'$' anchors, one '*' wildcard and optional case folding.
module sme_param #(
  parameter int STR_LEN = 32,
  parameter int PAT_LEN = 8,
  parameter int IDX_W   = $clog2(STR_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  input  logic             nocase,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic             busy
);

  localparam int LW  = $clog2(STR_LEN + 1);
  localparam int PW  = $clog2(PAT_LEN + 1);
  localparam int SIW = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;
  localparam int PIW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int SW  = $clog2(STR_LEN + PAT_LEN + 2);

  typedef enum logic [2:0] {IDLE, LD_STR, LD_PAT, SEARCH, DONE} state_t;
  typedef enum logic {PH_PRE, PH_SUF} phase_t;

  logic [7:0]       str_q [STR_LEN];
  logic [7:0]       pat_q [PAT_LEN];
  logic [LW-1:0]    str_len_q;
  logic [PW-1:0]    pat_len_q;
  logic             nocase_q;
  state_t           state_q, state_n;
  phase_t           ph_q, ph_n;
  logic [SW-1:0]    s_q, s_n, t_q, t_n;
  logic [PW-1:0]    k_q, k_n, j_q, j_n;
  logic             match_q;
  logic [IDX_W-1:0] idx_q;

  logic             load_ok, str_wr, pat_wr, str_restart, pat_restart;
  logic [LW-1:0]    str_addr;
  logic [PW-1:0]    pat_addr;

  logic             anc_s, anc_e, has_star, no_tok;
  logic [PW-1:0]    last, ps, pe, star_pos, pre_len, suf_lo, suf_len;

  logic [SW-1:0]    len_w, pos_pre, pos_suf;
  logic             start_ok, pre_eq, suf_eq, pre_end_ok, suf_end_ok;
  logic             adv, nxt_t, fin, hit_n;

  function automatic logic is_alpha(input logic [7:0] x);
    return ((x >= 8'h41) && (x <= 8'h5A)) || ((x >= 8'h61) && (x <= 8'h7A));
  endfunction

  function automatic logic chr_eq(input logic [7:0] c, input logic [7:0] p, input logic nc);
    if (p == 8'h2E) return 1'b1;
    if (c == p) return 1'b1;
    return nc && is_alpha(c) && is_alpha(p) && ((c | 8'h20) == (p | 8'h20));
  endfunction

  function automatic logic [7:0] str_at(input logic [SW-1:0] pos);
    if (pos < SW'(STR_LEN)) return str_q[pos[SIW-1:0]];
    return 8'h00;
  endfunction

  function automatic logic [7:0] pat_at(input logic [PW-1:0] pos);
    if (pos < PW'(PAT_LEN)) return pat_q[pos[PIW-1:0]];
    return 8'h00;
  endfunction

  // Load decode: a new string/pattern restarts whenever the previous cycle was not loading it
  always_comb begin
    load_ok     = (state_q == IDLE) || (state_q == LD_STR) ||
                  (state_q == LD_PAT) || (state_q == DONE);
    str_wr      = load_ok && isstring;
    pat_wr      = load_ok && !isstring && ispattern;
    str_restart = (state_q != LD_STR);
    pat_restart = (state_q != LD_PAT);
    str_addr    = str_restart ? '0 : str_len_q;
    pat_addr    = pat_restart ? '0 : pat_len_q;
  end

  always_ff @(posedge clk) begin
    if (str_wr && (str_addr < LW'(STR_LEN))) str_q[str_addr[SIW-1:0]] <= chardata;
    if (pat_wr && (pat_addr < PW'(PAT_LEN))) pat_q[pat_addr[PIW-1:0]] <= chardata;
  end

  // Pattern parse: prefix tokens sit between the optional '^' and the first '*', suffix after it
  always_comb begin
    last     = pat_len_q - PW'(1);
    anc_s    = (pat_len_q != '0) && (pat_at('0) == 8'h5E);
    anc_e    = (pat_len_q != '0) && (pat_at(last) == 8'h24);
    ps       = anc_s ? PW'(1) : '0;
    pe       = anc_e ? last : pat_len_q;
    has_star = 1'b0;
    star_pos = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (!has_star && (PW'(i) >= ps) && (PW'(i) < pe) && (pat_q[i] == 8'h2A)) begin
        has_star = 1'b1;
        star_pos = PW'(i);
      end
    end
    pre_len  = has_star ? (star_pos - ps) : (pe - ps);
    suf_lo   = star_pos + PW'(1);
    suf_len  = has_star ? (pe - star_pos - PW'(1)) : '0;
    no_tok   = (pre_len == '0) && (suf_len == '0);
  end

  always_comb begin
    len_w      = SW'(str_len_q);
    pos_pre    = s_q + SW'(k_q);
    pos_suf    = t_q + SW'(j_q);
    start_ok   = !anc_s || (s_q == '0) || (str_at(s_q - SW'(1)) == 8'h20);
    pre_eq     = chr_eq(str_at(pos_pre), pat_at(ps + k_q), nocase_q);
    suf_eq     = chr_eq(str_at(pos_suf), pat_at(suf_lo + j_q), nocase_q);
    pre_end_ok = !anc_e || (pos_pre == len_w) || (str_at(pos_pre) == 8'h20);
    suf_end_ok = !anc_e || (pos_suf == len_w) || (str_at(pos_suf) == 8'h20);
  end

  // Next-state and search stepping
  always_comb begin
    state_n = state_q;
    ph_n    = ph_q;
    s_n     = s_q;
    k_n     = k_q;
    t_n     = t_q;
    j_n     = j_q;
    adv     = 1'b0;
    nxt_t   = 1'b0;
    fin     = 1'b0;
    hit_n   = 1'b0;
    case (state_q)
      IDLE, LD_STR, DONE: begin
        if (isstring)       state_n = LD_STR;
        else if (ispattern) state_n = LD_PAT;
        else                state_n = IDLE;
      end
      LD_PAT: begin
        if (isstring)       state_n = LD_STR;
        else if (ispattern) state_n = LD_PAT;
        else begin
          state_n = SEARCH;
          ph_n    = PH_PRE;
          s_n     = '0;
          k_n     = '0;
          t_n     = '0;
          j_n     = '0;
        end
      end
      SEARCH: begin
        if ((str_len_q == '0) || no_tok) begin
          fin = 1'b1;
        end else if (ph_q == PH_PRE) begin
          if (!start_ok || ((k_q != pre_len) && ((pos_pre >= len_w) || !pre_eq))) begin
            adv = 1'b1;
          end else if (k_q == pre_len) begin
            if (has_star) begin
              ph_n = PH_SUF;
              t_n  = pos_pre;
              j_n  = '0;
            end else if (pre_end_ok) begin
              fin   = 1'b1;
              hit_n = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end else begin
            k_n = k_q + PW'(1);
          end
          if (adv) begin
            if (s_q + SW'(1) >= len_w) fin = 1'b1;
            else begin
              s_n = s_q + SW'(1);
              k_n = '0;
            end
          end
        end else begin
          // The suffix search range only shrinks as s grows, so a suffix miss ends the search
          if (j_q == suf_len) begin
            if ((suf_len == '0) || suf_end_ok) begin
              fin   = 1'b1;
              hit_n = 1'b1;
            end else begin
              nxt_t = 1'b1;
            end
          end else if ((pos_suf >= len_w) || !suf_eq) begin
            nxt_t = 1'b1;
          end else begin
            j_n = j_q + PW'(1);
          end
          if (nxt_t) begin
            if (t_q + SW'(1) >= len_w) fin = 1'b1;
            else begin
              t_n = t_q + SW'(1);
              j_n = '0;
            end
          end
        end
        if (fin) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ph_q      <= PH_PRE;
      s_q       <= '0;
      k_q       <= '0;
      t_q       <= '0;
      j_q       <= '0;
      str_len_q <= '0;
      pat_len_q <= '0;
      nocase_q  <= 1'b0;
      match_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q <= state_n;
      ph_q    <= ph_n;
      s_q     <= s_n;
      k_q     <= k_n;
      t_q     <= t_n;
      j_q     <= j_n;
      if (str_wr) begin
        if (str_restart)                  str_len_q <= LW'(1);
        else if (str_len_q < LW'(STR_LEN)) str_len_q <= str_len_q + LW'(1);
      end
      if (pat_wr) begin
        if (pat_restart) begin
          pat_len_q <= PW'(1);
          nocase_q  <= nocase;
        end else if (pat_len_q < PW'(PAT_LEN)) begin
          pat_len_q <= pat_len_q + PW'(1);
        end
      end
      if ((state_q == SEARCH) && fin) begin
        match_q <= hit_n;
        idx_q   <= hit_n ? s_q[IDX_W-1:0] : '0;
      end
    end
  end

  assign valid       = (state_q == DONE);
  assign busy        = (state_q == LD_PAT) || (state_q == SEARCH);
  assign match       = match_q;
  assign match_index = idx_q;

endmodule

// File: tb/tb_sme_param.sv
// Directed bench for sme_param: string/pattern loads with hand-computed match results.
module tb_sme_param;

  localparam int STR_LEN = 32;
  localparam int PAT_LEN = 8;
  localparam int IDX_W   = $clog2(STR_LEN);
  localparam int LIMIT   = 12000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       chardata = 8'h00;
  logic             isstring = 1'b0;
  logic             ispattern = 1'b0;
  logic             nocase = 1'b0;
  logic             valid, match, busy;
  logic [IDX_W-1:0] match_index;

  int n_cmp = 0;
  int n_bad = 0;

  sme_param #(.STR_LEN(STR_LEN), .PAT_LEN(PAT_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .nocase(nocase), .valid(valid), .match(match),
    .match_index(match_index), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      isstring = 1'b1;
      chardata = s[i];
    end
    @(posedge clk); #1;
    isstring = 1'b0;
    chardata = 8'h00;
  endtask

  task automatic send_pat(input string p, input logic nc);
    for (int i = 0; i < p.len(); i++) begin
      @(posedge clk); #1;
      ispattern = 1'b1;
      nocase    = nc;
      chardata  = p[i];
    end
    @(posedge clk); #1;
    ispattern = 1'b0;
    chardata  = 8'h00;
  endtask

  task automatic run_pat(input string tag, input string p, input logic nc,
                         input logic em, input int ei);
    logic got;
    send_pat(p, nc);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      if (valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_valid"}, got, 1);
    if (got) begin
      chk({tag, "_match"}, match, em);
      if (em) chk({tag, "_idx"}, match_index, ei);
      chk({tag, "_busy_at_valid"}, busy, 0);
      @(negedge clk);
      chk({tag, "_pulse"}, valid, 0);
    end
  endtask

  initial begin
    string a40;
    int vhi;
    a40 = "";
    for (int i = 0; i < 40; i++) a40 = {a40, "a"};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_match", match, 0);
    chk("rst_idx", match_index, 0);
    chk("rst_busy", busy, 0);

    load_str("the cat sat");
    run_pat("at",    "at",    1'b0, 1'b1, 5);
    run_pat("caret", "^s",    1'b0, 1'b1, 8);
    run_pat("dollar","t$",    1'b0, 1'b1, 6);
    run_pat("dog",   "dog",   1'b0, 1'b0, 0);
    run_pat("cstar", "c*t$",  1'b0, 1'b1, 4);
    run_pat("lstar", "*sat$", 1'b0, 1'b1, 0);
    run_pat("dotz",  ".a*z",  1'b0, 1'b0, 0);
    run_pat("nc_AT", "AT",    1'b1, 1'b1, 5);
    run_pat("cs_AT", "AT",    1'b0, 1'b0, 0);
    run_pat("nc_HE", "^.HE",  1'b1, 1'b1, 0);

    load_str(a40);
    run_pat("ovf_str", "a$", 1'b0, 1'b1, 31);

    // Abort a running search with reset
    send_pat("q*z", 1'b0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_match", match, 0);
    chk("abort_idx", match_index, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    vhi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) vhi++;
    end
    chk("abort_no_valid", vhi, 0);

    run_pat("empty_str", "a", 1'b0, 1'b0, 0);
    load_str("ab");
    run_pat("ab_b", "b", 1'b0, 1'b1, 1);

    load_str(a40);
    run_pat("ovf_pat", "aaaaaaaaaa", 1'b0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
